// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter: FIFO entry layout, scheduler
// states and source identifiers.
package uart_tx_arbiter_pkg;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } UartTxEntry_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_ACK,
        WAIT_DONE,
        WAIT_NEXT
    } UartTxArbState_t;

    localparam logic UART_SRC_KEYBOARD = 1'b0;
    localparam logic UART_SRC_PARSER   = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream handshakes of the two requesters plus the transmitter-side
// start/data/busy link and the arbiter status outputs.
interface uart_tx_arbiter_if;

    logic       kbValid;
    logic [7:0] kbData;
    logic       kbLast;
    logic       kbReady;
    logic       repValid;
    logic [7:0] repData;
    logic       repLast;
    logic       repReady;
    logic       txStart;
    logic [7:0] txData;
    logic       txBusy;
    logic       grantSrc;
    logic       locked;
    logic [7:0] timeoutCount;

    modport master (
        output kbValid, kbData, kbLast, repValid, repData, repLast, txBusy,
        input  kbReady, repReady, txStart, txData, grantSrc, locked, timeoutCount
    );

    modport slave (
        input  kbValid, kbData, kbLast, repValid, repData, repLast, txBusy,
        output kbReady, repReady, txStart, txData, grantSrc, locked, timeoutCount
    );

endinterface

// File: rtl/uart_tx_arbiter_sync_byte_fifo.sv
// Single-clock FIFO of {last,data} entries; full is registered so the
// requester-facing ready has no combinational path from the pop side.
module sync_byte_fifo
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  UartTxEntry_t     push_data,
    input  logic             pop,
    output UartTxEntry_t     pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    UartTxEntry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CNT_W-1:0] count_nxt;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_push   = push && (!full || pop);
    assign do_pop    = pop && !empty;
    assign count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
    assign empty     = (count == '0);
    assign pop_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin scheduler sharing one UART transmitter between
// keyboard output and VT100 parser replies.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int ACK_TIMEOUT    = 4,
    parameter int PACKET_TIMEOUT = 100000
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
    localparam int PKT_W = $clog2(PACKET_TIMEOUT + 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(PACKET_TIMEOUT - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    UartTxArbState_t  state;
    UartTxEntry_t     kb_head, rep_head, grant_head;
    logic             kb_full, kb_empty, rep_full, rep_empty;
    logic [CNT_W-1:0] kb_count, rep_count;
    logic             kb_push, rep_push, kb_pop, rep_pop;
    logic             grant_avail;
    logic             rr_ptr, last_flag, grant_src, locked_q, tx_start_q;
    logic [7:0]       tx_data_q, timeout_cnt;
    logic [ACK_W-1:0] ack_cnt;
    logic [PKT_W-1:0] pkt_cnt;

    assign kb_push      = bus.kbValid && bus.kbReady;
    assign rep_push     = bus.repValid && bus.repReady;
    assign kb_pop       = (state == LOAD) && (grant_src == UART_SRC_KEYBOARD);
    assign rep_pop      = (state == LOAD) && (grant_src == UART_SRC_PARSER);
    assign grant_head   = grant_src ? rep_head : kb_head;
    assign grant_avail  = (grant_src ? rep_count : kb_count) != '0;

    assign bus.kbReady      = !kb_full;
    assign bus.repReady     = !rep_full;
    assign bus.txStart      = tx_start_q;
    assign bus.txData       = tx_data_q;
    assign bus.grantSrc     = grant_src;
    assign bus.locked       = locked_q;
    assign bus.timeoutCount = timeout_cnt;

    sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_kb_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (kb_push),
        .push_data ({bus.kbLast, bus.kbData}),
        .pop       (kb_pop),
        .pop_data  (kb_head),
        .full      (kb_full),
        .empty     (kb_empty),
        .count     (kb_count)
    );

    sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rep_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (rep_push),
        .push_data ({bus.repLast, bus.repData}),
        .pop       (rep_pop),
        .pop_data  (rep_head),
        .full      (rep_full),
        .empty     (rep_empty),
        .count     (rep_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            last_flag   <= 1'b0;
            grant_src   <= 1'b0;
            locked_q    <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            timeout_cnt <= 8'h00;
            ack_cnt     <= '0;
            pkt_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!kb_empty || !rep_empty) begin
                        if (!kb_empty && !rep_empty) grant_src <= rr_ptr;
                        else if (!rep_empty)         grant_src <= UART_SRC_PARSER;
                        else                         grant_src <= UART_SRC_KEYBOARD;
                        locked_q <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    tx_data_q  <= grant_head.data;
                    last_flag  <= grant_head.last;
                    tx_start_q <= 1'b1;
                    state      <= START;
                end
                START: begin
                    tx_start_q <= 1'b0;
                    ack_cnt    <= '0;
                    state      <= WAIT_ACK;
                end
                // A transmitter that never raises busy must not stall the scheduler.
                WAIT_ACK: begin
                    if (bus.txBusy) begin
                        state <= WAIT_DONE;
                    end else if (ack_cnt == ACK_LAST) begin
                        timeout_cnt <= sat_inc(timeout_cnt);
                        state       <= WAIT_DONE;
                    end else begin
                        ack_cnt <= ack_cnt + ACK_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!bus.txBusy) begin
                        if (last_flag) begin
                            locked_q <= 1'b0;
                            rr_ptr   <= ~grant_src;
                            state    <= IDLE;
                        end else if (grant_avail) begin
                            state <= LOAD;
                        end else begin
                            pkt_cnt <= '0;
                            state   <= WAIT_NEXT;
                        end
                    end
                end
                // Lock is held across gaps so sequences never interleave.
                WAIT_NEXT: begin
                    if (grant_avail) begin
                        state <= LOAD;
                    end else if (pkt_cnt == PKT_LAST) begin
                        locked_q    <= 1'b0;
                        rr_ptr      <= ~grant_src;
                        timeout_cnt <= sat_inc(timeout_cnt);
                        state       <= IDLE;
                    end else begin
                        pkt_cnt <= pkt_cnt + PKT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter busy model and
// an output log of {grantSrc, txData} captured at every start pulse.
module tb_uart_tx_arbiter;

    localparam int PKT_TO = 60;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(
        .FIFO_DEPTH     (16),
        .ACK_TIMEOUT    (4),
        .PACKET_TIMEOUT (PKT_TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         last_start_cyc = 0;
    int         busy_cnt = 0;
    int         busy_len = 6;
    bit         busy_en = 1'b1;
    bit         pend = 1'b0;
    int         busy_viol = 0;
    logic [8:0] out_q [$];
    int         st_a, st_b, base, delta;
    logic [8:0] exp_sim [9] = '{9'h01B, 9'h05B, 9'h041, 9'h11B, 9'h15B,
                                9'h131, 9'h13B, 9'h131, 9'h152};

    assign bus.txBusy = (busy_cnt != 0);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Transmitter model: busy rises one cycle after start and holds busy_len cycles.
    always @(negedge clk) begin
        if (busy_cnt > 0) busy_cnt--;
        if (pend) begin
            pend = 1'b0;
            if (busy_en) busy_cnt = busy_len;
        end
        if (bus.txStart) begin
            if (bus.txBusy) busy_viol++;
            out_q.push_back({bus.grantSrc, bus.txData});
            last_start_cyc = cyc;
            pend = 1'b1;
        end
    end

    task automatic push(input logic src, input logic [7:0] d, input logic l, output int stall);
        stall = 0;
        if (src) begin bus.repValid = 1'b1; bus.repData = d; bus.repLast = l; end
        else     begin bus.kbValid  = 1'b1; bus.kbData  = d; bus.kbLast  = l; end
        while (((src && !bus.repReady) || (!src && !bus.kbReady)) && stall < 400) begin
            @(negedge clk);
            stall++;
        end
        if (stall >= 400) check_eq("push_ready", src ? bus.repReady : bus.kbReady, 1);
        @(negedge clk);
        if (src) bus.repValid = 1'b0;
        else     bus.kbValid  = 1'b0;
    endtask

    task automatic wait_locked(input logic v, input string tag);
        int t = 0;
        while (bus.locked !== v && t < 500) begin @(negedge clk); t++; end
        if (t >= 500) check_eq(tag, bus.locked, v);
    endtask

    task automatic wait_out(input int n);
        int t = 0;
        while ((out_q.size() < n || bus.locked || bus.txBusy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_eq("out_count", out_q.size(), n);
    endtask

    initial begin
        bus.kbValid = 1'b0; bus.kbData = 8'h00; bus.kbLast = 1'b0;
        bus.repValid = 1'b0; bus.repData = 8'h00; bus.repLast = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_txStart", bus.txStart, 0);
        check_eq("rst_txData", bus.txData, 0);
        check_eq("rst_locked", bus.locked, 0);
        check_eq("rst_grantSrc", bus.grantSrc, 0);
        check_eq("rst_timeout", bus.timeoutCount, 0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_kbReady", bus.kbReady, 1);
        check_eq("rst_repReady", bus.repReady, 1);

        // Single byte
        busy_len = 10;
        push(1'b0, 8'h61, 1'b1, st_a);
        wait_locked(1'b1, "t1_lock");
        while (!bus.txBusy && st_b < 100) begin @(negedge clk); st_b++; end
        check_eq("t1_locked_busy", bus.locked, 1);
        wait_out(1);
        check_eq("t1_byte", out_q[0], 9'h061);
        check_eq("t1_txData", bus.txData, 8'h61);
        check_eq("t1_locked_after", bus.locked, 0);

        // Contention after a keyboard packet goes to the parser
        busy_len = 6;
        fork
            push(1'b0, 8'h11, 1'b1, st_a);
            push(1'b1, 8'h22, 1'b1, st_b);
        join
        wait_out(3);
        check_eq("rr_first", out_q[1], 9'h122);
        check_eq("rr_second", out_q[2], 9'h011);

        // Back-pressure: parser holds the lock mid-packet while keyboard fills
        busy_len = 4;
        base = out_q.size();
        push(1'b1, 8'hAA, 1'b0, st_a);
        wait_locked(1'b1, "bp_lock");
        for (int i = 0; i < 16; i++) push(1'b0, 8'(8'h30 + i), 1'b0, st_a);
        check_eq("bp_kbReady_full", bus.kbReady, 0);
        check_eq("bp_grant_held", bus.grantSrc, 1);
        fork
            push(1'b0, 8'h40, 1'b1, st_a);
            begin repeat (5) @(negedge clk); push(1'b1, 8'hBB, 1'b1, st_b); end
        join
        check_eq("bp_17th_stalled", (st_a > 0), 1);
        wait_out(base + 19);
        check_eq("bp_rep0", out_q[base], 9'h1AA);
        check_eq("bp_rep1", out_q[base + 1], 9'h1BB);
        for (int i = 0; i < 17; i++) check_eq("bp_kb", out_q[base + 2 + i], 9'(9'h030 + i));

        // ACK timeout with busy never rising
        busy_en = 1'b0;
        base = out_q.size();
        push(1'b0, 8'h41, 1'b1, st_a);
        wait_locked(1'b1, "ack_lock");
        wait_locked(1'b0, "ack_release");
        delta = cyc - last_start_cyc;
        check_eq("ack_release_delay", delta, 6);
        check_eq("ack_timeout_cnt", bus.timeoutCount, 1);
        check_eq("ack_byte", out_q[base], 9'h041);
        busy_en = 1'b1;
        push(1'b0, 8'h42, 1'b1, st_a);
        wait_out(base + 2);
        check_eq("ack_next_byte", out_q[base + 1], 9'h042);
        check_eq("ack_next_cnt", bus.timeoutCount, 1);

        // Packet timeout: keyboard stalls mid-packet, parser waits its turn
        base = out_q.size();
        push(1'b0, 8'h1B, 1'b0, st_a);
        wait_locked(1'b1, "pkt_lock");
        push(1'b1, 8'h52, 1'b1, st_b);
        repeat (25) @(negedge clk);
        check_eq("pkt_hold_locked", bus.locked, 1);
        check_eq("pkt_hold_grant", bus.grantSrc, 0);
        check_eq("pkt_hold_count", out_q.size(), base + 1);
        wait_out(base + 2);
        check_eq("pkt_kb_byte", out_q[base], 9'h01B);
        check_eq("pkt_rep_byte", out_q[base + 1], 9'h152);
        check_eq("pkt_timeout_cnt", bus.timeoutCount, 2);

        // Asynchronous reset during WAIT_DONE
        busy_len = 10;
        push(1'b0, 8'h77, 1'b0, st_a);
        push(1'b0, 8'h78, 1'b1, st_a);
        st_b = 0;
        while (!bus.txBusy && st_b < 100) begin @(negedge clk); st_b++; end
        @(negedge clk);
        base = out_q.size();
        #2 rst = 1'b0;
        #1;
        check_eq("arst_txStart", bus.txStart, 0);
        check_eq("arst_txData", bus.txData, 0);
        check_eq("arst_locked", bus.locked, 0);
        check_eq("arst_timeout", bus.timeoutCount, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("arst_kbReady", bus.kbReady, 1);
        repeat (30) @(negedge clk);
        check_eq("arst_no_stale", out_q.size(), base);
        check_eq("arst_locked_after", bus.locked, 0);

        // Simultaneous multi-byte packets, pointer starts at keyboard
        busy_len = 5;
        base = out_q.size();
        fork
            begin
                push(1'b0, 8'h1B, 1'b0, st_a);
                push(1'b0, 8'h5B, 1'b0, st_a);
                push(1'b0, 8'h41, 1'b1, st_a);
            end
            begin
                push(1'b1, 8'h1B, 1'b0, st_b);
                push(1'b1, 8'h5B, 1'b0, st_b);
                push(1'b1, 8'h31, 1'b0, st_b);
                push(1'b1, 8'h3B, 1'b0, st_b);
                push(1'b1, 8'h31, 1'b0, st_b);
                push(1'b1, 8'h52, 1'b1, st_b);
            end
        join
        wait_out(base + 9);
        for (int i = 0; i < 9; i++) check_eq("sim_order", out_q[base + i], exp_sim[i]);

        check_eq("start_while_busy", busy_viol, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
